// File: rtl/frame_stream_ctrl.sv
// frame_stream_ctrl
//   Turns the frame_counter raster generator into a flow-controlled
//   pixel-coordinate stream. It sequences start/stop/abort commands, inserts
//   a programmable blanking gap between frames, and counts completed frames.
//
// Ports
//   clk, reset_n         single clock, asynchronous active-low reset
//   start, stop, abort   single-cycle command pulses
//   single               1 = one frame per start, 0 = continuous
//   pix_valid/pix_ready  downstream valid/ready handshake
//   pix_x, pix_y         current coordinate
//   pix_sof/eol/eof      beat is (0,0) / last pixel of line / last of frame
//   busy                 controller not idle
//   frame_done           one-cycle pulse after the eof beat transfers
//   frame_count          completed frames since reset (wraps)

// frame_counter
//   Raster counter. hcount runs 0..HMAX-1, vcount advances on the line wrap
//   and runs 0..VMAX-1. sync_clr has priority over inc.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   inc                  advance one pixel
//   sync_clr             synchronous clear to (0,0)
//   hcount, vcount       current coordinate
module frame_counter #(
    parameter int HMAX         = 640,
    parameter int VMAX         = 480,
    parameter int COUNTER_BITS = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inc,
    input  logic                    sync_clr,
    output logic [COUNTER_BITS-1:0] hcount,
    output logic [COUNTER_BITS-1:0] vcount
);

    localparam logic [COUNTER_BITS-1:0] H_LAST = COUNTER_BITS'(HMAX - 1);
    localparam logic [COUNTER_BITS-1:0] V_LAST = COUNTER_BITS'(VMAX - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (sync_clr) begin
            hcount <= '0;
            vcount <= '0;
        end else if (inc) begin
            if (hcount == H_LAST) begin
                hcount <= '0;
                if (vcount == V_LAST) begin
                    vcount <= '0;
                end else begin
                    vcount <= vcount + COUNTER_BITS'(1);
                end
            end else begin
                hcount <= hcount + COUNTER_BITS'(1);
            end
        end
    end

endmodule

// State table
//   state    | meaning
//   S_IDLE   | not streaming, waiting for start
//   S_CLEAR  | one cycle clearing the raster counter
//   S_ACTIVE | presenting beats (pix_valid = 1)
//   S_GAP    | blanking between frames in continuous mode
module frame_stream_ctrl #(
    parameter int HMAX         = 640,
    parameter int VMAX         = 480,
    parameter int COUNTER_BITS = 32,
    parameter int GAP_CYCLES   = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    abort,
    input  logic                    single,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic [COUNTER_BITS-1:0] pix_x,
    output logic [COUNTER_BITS-1:0] pix_y,
    output logic                    pix_sof,
    output logic                    pix_eol,
    output logic                    pix_eof,
    output logic                    busy,
    output logic                    frame_done,
    output logic [15:0]             frame_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_ACTIVE = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD =
        (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    localparam logic [COUNTER_BITS-1:0] H_LAST = COUNTER_BITS'(HMAX - 1);
    localparam logic [COUNTER_BITS-1:0] V_LAST = COUNTER_BITS'(VMAX - 1);

    state_t           state, state_nxt;
    logic             stop_pending, stop_pending_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
    logic             done_nxt;
    logic             sync_clr;
    logic             inc;
    logic             eof_xfer;

    frame_counter #(
        .HMAX        (HMAX),
        .VMAX        (VMAX),
        .COUNTER_BITS(COUNTER_BITS)
    ) u_frame_counter (
        .clk     (clk),
        .reset   (~reset_n),
        .inc     (inc),
        .sync_clr(sync_clr),
        .hcount  (pix_x),
        .vcount  (pix_y)
    );

    assign pix_valid = (state == S_ACTIVE);
    assign busy      = (state != S_IDLE);
    assign inc       = pix_valid & pix_ready;
    assign pix_sof   = (pix_x == '0) && (pix_y == '0);
    assign pix_eol   = (pix_x == H_LAST);
    assign pix_eof   = pix_eol && (pix_y == V_LAST);
    assign eof_xfer  = inc & pix_eof;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            stop_pending <= 1'b0;
            gap_cnt      <= '0;
            frame_done   <= 1'b0;
            frame_count  <= '0;
        end else begin
            state        <= state_nxt;
            stop_pending <= stop_pending_nxt;
            gap_cnt      <= gap_cnt_nxt;
            frame_done   <= done_nxt;
            if (done_nxt) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    always_comb begin
        state_nxt        = state;
        stop_pending_nxt = stop_pending;
        gap_cnt_nxt      = gap_cnt;
        done_nxt         = 1'b0;
        sync_clr         = 1'b0;

        case (state)
            S_IDLE: begin
                if (start && !stop && !abort) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                sync_clr = 1'b1;
                if (stop) begin
                    stop_pending_nxt = 1'b1;
                end
                state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (stop) begin
                    stop_pending_nxt = 1'b1;
                end
                if (eof_xfer) begin
                    done_nxt = 1'b1;
                    // A stop landing on the eof beat itself still ends here.
                    if (stop_pending || stop || single) begin
                        state_nxt = S_IDLE;
                    end else if (GAP_CYCLES == 0) begin
                        state_nxt = S_ACTIVE;
                    end else begin
                        state_nxt   = S_GAP;
                        gap_cnt_nxt = GAP_LOAD;
                    end
                end
            end
            S_GAP: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (gap_cnt == '0) begin
                    state_nxt = S_ACTIVE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Abort overrides everything, including an eof transfer this cycle.
        if (abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
            sync_clr  = 1'b1;
            done_nxt  = 1'b0;
        end

        if (state_nxt == S_IDLE) begin
            stop_pending_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_frame_stream_ctrl.sv
// tb_frame_stream_ctrl
//   Directed bench for frame_stream_ctrl with a 4x3 raster. dut uses a
//   two-cycle blanking gap, dut0 runs back-to-back frames; both share inputs.
module tb_frame_stream_ctrl;

    localparam int HM = 4;
    localparam int VM = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        abort = 1'b0;
    logic        single = 1'b0;
    logic        pix_ready = 1'b0;

    logic        pix_valid, pix_sof, pix_eol, pix_eof, busy, frame_done;
    logic [31:0] pix_x, pix_y;
    logic [15:0] frame_count;

    logic        pix_valid0, pix_sof0, pix_eol0, pix_eof0, busy0, frame_done0;
    logic [31:0] pix_x0, pix_y0;
    logic [15:0] frame_count0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    frame_stream_ctrl #(.HMAX(HM), .VMAX(VM), .COUNTER_BITS(32), .GAP_CYCLES(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .abort(abort),
        .single(single), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol),
        .pix_eof(pix_eof), .busy(busy), .frame_done(frame_done),
        .frame_count(frame_count)
    );

    frame_stream_ctrl #(.HMAX(HM), .VMAX(VM), .COUNTER_BITS(32), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .abort(abort),
        .single(single), .pix_valid(pix_valid0), .pix_ready(pix_ready),
        .pix_x(pix_x0), .pix_y(pix_y0), .pix_sof(pix_sof0), .pix_eol(pix_eol0),
        .pix_eof(pix_eof0), .busy(busy0), .frame_done(frame_done0),
        .frame_count(frame_count0)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        abort     = 1'b0;
        pix_ready = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Expected beat k of a frame (raster order) on dut.
    task automatic check_beat(input string tag, input int k);
        check_val({tag, "_valid"}, 32'(pix_valid), 32'd1);
        check_val({tag, "_x"},     pix_x, 32'(k % HM));
        check_val({tag, "_y"},     pix_y, 32'(k / HM));
        check_val({tag, "_sof"},   32'(pix_sof), 32'(k == 0));
        check_val({tag, "_eol"},   32'(pix_eol), 32'((k % HM) == HM - 1));
        check_val({tag, "_eof"},   32'(pix_eof), 32'(k == HM * VM - 1));
    endtask

    task automatic start_cmd(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val({tag, "_clr_busy"},  32'(busy), 32'd1);
        check_val({tag, "_clr_valid"}, 32'(pix_valid), 32'd0);
        tick();
        check_beat({tag, "_first"}, 0);
    endtask

    initial begin
        int k, gap, cyc;
        bit in_gap;

        // Reset values
        do_reset();
        check_val("rst_valid", 32'(pix_valid), 32'd0);
        check_val("rst_x",     pix_x, 32'd0);
        check_val("rst_y",     pix_y, 32'd0);
        check_val("rst_sof",   32'(pix_sof), 32'd1);
        check_val("rst_eol",   32'(pix_eol), 32'd0);
        check_val("rst_eof",   32'(pix_eof), 32'd0);
        check_val("rst_busy",  32'(busy), 32'd0);
        check_val("rst_done",  32'(frame_done), 32'd0);
        check_val("rst_fcnt",  32'(frame_count), 32'd0);

        // Single frame, always ready
        single    = 1'b1;
        pix_ready = 1'b1;
        start_cmd("s1");
        for (int i = 0; i < HM * VM; i++) begin
            check_beat("s1_beat", i);
            check_val("s1_done_lo", 32'(frame_done), 32'd0);
            tick();
        end
        check_val("s1_done",  32'(frame_done), 32'd1);
        check_val("s1_fcnt",  32'(frame_count), 32'd1);
        check_val("s1_busy",  32'(busy), 32'd0);
        check_val("s1_valid", 32'(pix_valid), 32'd0);
        tick();
        check_val("s1_done_once", 32'(frame_done), 32'd0);

        // Continuous with ready pattern 1,0,0 repeating
        do_reset();
        single = 1'b0;
        pix_ready = 1'b1;
        start_cmd("s2");
        k = 0; gap = 0; cyc = 0; in_gap = 1'b0;
        while (k < 3 * HM * VM && cyc < 500) begin
            pix_ready = (cyc % 3 == 0);
            if (pix_valid) begin
                if (in_gap) begin
                    check_val("s2_gap_len", 32'(gap), 32'd2);
                    in_gap = 1'b0;
                end
                check_beat("s2_beat", k % (HM * VM));
                if (pix_ready) begin
                    if (k % (HM * VM) == HM * VM - 1) begin
                        in_gap = 1'b1;
                        gap = 0;
                    end
                    k++;
                end
            end else if (in_gap) begin
                gap++;
            end
            tick();
            cyc++;
        end
        check_val("s2_beats", 32'(k), 32'(3 * HM * VM));
        check_val("s2_fcnt",  32'(frame_count), 32'd3);
        check_val("s2_done",  32'(frame_done), 32'd1);
        check_val("s2_gap_valid", 32'(pix_valid), 32'd0);
        check_val("s2_gap_busy",  32'(busy), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_val("s2_stop_in_gap", 32'(busy), 32'd0);

        // Graceful stop at the 5th beat, continuous
        do_reset();
        single = 1'b0;
        pix_ready = 1'b1;
        start_cmd("s3");
        for (int i = 0; i < HM * VM; i++) begin
            check_beat("s3_beat", i);
            if (i == 4) stop = 1'b1;
            tick();
            stop = 1'b0;
        end
        check_val("s3_done",  32'(frame_done), 32'd1);
        check_val("s3_fcnt",  32'(frame_count), 32'd1);
        check_val("s3_busy",  32'(busy), 32'd0);
        check_val("s3_valid", 32'(pix_valid), 32'd0);
        tick();
        check_val("s3_no_gap", 32'(busy), 32'd0);

        // Abort at the 5th beat, then abort on the eof beat
        do_reset();
        single = 1'b0;
        pix_ready = 1'b1;
        start_cmd("s4");
        for (int i = 0; i < 5; i++) begin
            check_beat("s4_beat", i);
            if (i == 4) abort = 1'b1;
            tick();
            abort = 1'b0;
        end
        check_val("s4_ab_valid", 32'(pix_valid), 32'd0);
        check_val("s4_ab_x",     pix_x, 32'd0);
        check_val("s4_ab_y",     pix_y, 32'd0);
        check_val("s4_ab_busy",  32'(busy), 32'd0);
        check_val("s4_ab_done",  32'(frame_done), 32'd0);
        tick();
        check_val("s4_ab_done2", 32'(frame_done), 32'd0);
        check_val("s4_ab_fcnt",  32'(frame_count), 32'd0);
        start_cmd("s4r");
        for (int i = 0; i < HM * VM; i++) begin
            check_beat("s4r_beat", i);
            if (i == HM * VM - 1) abort = 1'b1;
            tick();
            abort = 1'b0;
        end
        check_val("s4_eofab_done", 32'(frame_done), 32'd0);
        check_val("s4_eofab_fcnt", 32'(frame_count), 32'd0);
        check_val("s4_eofab_busy", 32'(busy), 32'd0);

        // start+stop together in IDLE; start during ACTIVE
        do_reset();
        pix_ready = 1'b1;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check_val("s5_ss_busy", 32'(busy), 32'd0);
        tick();
        check_val("s5_ss_busy2", 32'(busy), 32'd0);
        single = 1'b1;
        start_cmd("s5");
        for (int i = 0; i < HM * VM; i++) begin
            check_beat("s5_beat", i);
            if (i == 2) start = 1'b1;
            tick();
            start = 1'b0;
        end
        check_val("s5_fcnt", 32'(frame_count), 32'd1);
        check_val("s5_busy", 32'(busy), 32'd0);

        // Back-to-back frames on dut0, then async reset mid-frame
        do_reset();
        single = 1'b0;
        pix_ready = 1'b1;
        start_cmd("s6");
        for (int i = 0; i < HM * VM; i++) begin
            check_val("s6_x0", pix_x0, 32'(i % HM));
            check_val("s6_y0", pix_y0, 32'(i / HM));
            tick();
        end
        check_val("s6_b2b_valid", 32'(pix_valid0), 32'd1);
        check_val("s6_b2b_x",     pix_x0, 32'd0);
        check_val("s6_b2b_y",     pix_y0, 32'd0);
        check_val("s6_b2b_sof",   32'(pix_sof0), 32'd1);
        check_val("s6_b2b_done",  32'(frame_done0), 32'd1);
        check_val("s6_b2b_fcnt",  32'(frame_count0), 32'd1);
        repeat (3) tick();
        check_val("s6_pre_eol", 32'(pix_eol0), 32'd1);
        #1 reset_n = 1'b0;
        #2;
        check_val("s6_rst_valid", 32'(pix_valid0), 32'd0);
        check_val("s6_rst_x",     pix_x0, 32'd0);
        check_val("s6_rst_y",     pix_y0, 32'd0);
        check_val("s6_rst_sof",   32'(pix_sof0), 32'd1);
        check_val("s6_rst_eol",   32'(pix_eol0), 32'd0);
        check_val("s6_rst_eof",   32'(pix_eof0), 32'd0);
        check_val("s6_rst_busy",  32'(busy0), 32'd0);
        check_val("s6_rst_done",  32'(frame_done0), 32'd0);
        check_val("s6_rst_fcnt",  32'(frame_count0), 32'd0);
        check_val("s6_rst_fcnt_g", 32'(frame_count), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
